// File: rtl/sc_corrector_bank.sv
// Statistical-corrector bank: sums per-table signed counters plus a TAGE confidence term and
// overrides the TAGE direction when the sum is confident enough. Tables self-clear after reset.
module sc_corrector_bank #(
    parameter int NUM_TABLES = 4,
    parameter int ENTRIES    = 64,
    parameter int NUM_WAYS   = 2,
    parameter int CTR_W      = 6,
    parameter int VADDR_W    = 41,
    parameter int INST_OFF   = 1,
    parameter int THRES_INIT = 6,
    localparam int IDX_W     = $clog2(ENTRIES),
    localparam int SUM_W     = CTR_W + 5 + $clog2(NUM_TABLES)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_enable,
    input  logic                          io_s0_fire,
    input  logic [VADDR_W-1:0]            io_s0_pc,
    input  logic [NUM_TABLES*IDX_W-1:0]   io_s0_fhist,
    output logic                          io_s1_ready,
    input  logic                          io_s1_fire,
    input  logic [NUM_WAYS-1:0]           io_s1_tage_taken,
    input  logic [NUM_WAYS-1:0]           io_s1_tage_hit,
    input  logic [NUM_WAYS*3-1:0]         io_s1_tage_ctr,
    input  logic                          io_s2_fire,
    output logic                          io_s2_valid,
    output logic [NUM_WAYS-1:0]           io_s2_taken,
    output logic [NUM_WAYS-1:0]           io_s2_sc_used,
    output logic [NUM_WAYS*SUM_W-1:0]     io_s2_sum,
    input  logic                          io_update_valid,
    input  logic [VADDR_W-1:0]            io_update_pc,
    input  logic [NUM_TABLES*IDX_W-1:0]   io_update_fhist,
    input  logic [NUM_WAYS-1:0]           io_update_br_valid,
    input  logic [NUM_WAYS-1:0]           io_update_taken,
    input  logic [NUM_WAYS-1:0]           io_update_tage_taken,
    input  logic [NUM_WAYS-1:0]           io_update_sc_used,
    input  logic [NUM_WAYS*SUM_W-1:0]     io_update_sum,
    output logic [15:0]                   io_perf_override
);
    localparam logic [CTR_W-1:0] CTR_MAX = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MIN = {1'b1, {(CTR_W-1){1'b0}}};

    typedef enum logic {INIT, READY} state_t;

    state_t                               state;
    logic [IDX_W-1:0]                     init_idx;
    logic [CTR_W-1:0]                     tbl [NUM_TABLES][ENTRIES][NUM_WAYS];
    logic [NUM_TABLES-1:0][IDX_W-1:0]     s1_idx;
    logic                                 s1_valid;
    logic [7:0]                           thres [NUM_WAYS];
    logic signed [5:0]                    tc [NUM_WAYS];

    logic signed [SUM_W-1:0]              s1_sum [NUM_WAYS];
    logic [NUM_WAYS-1:0]                  s1_used, s1_over, s1_taken;
    logic [16:0]                          perf_acc;
    logic [15:0]                          perf_nxt;

    logic [NUM_TABLES-1:0][IDX_W-1:0]     u_idx;
    logic [CTR_W-1:0]                     u_nxt [NUM_TABLES][NUM_WAYS];
    logic [NUM_WAYS-1:0]                  u_wr, tc_inc, tc_dec;

    logic unused_ok;
    assign unused_ok = ^{io_s2_fire, io_s0_pc, io_update_pc};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= INIT;
            init_idx    <= '0;
            io_s1_ready <= 1'b0;
        end else if (state == INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == IDX_W'(ENTRIES - 1)) begin
                state       <= READY;
                io_s1_ready <= 1'b1;
            end
        end
    end

    // Storage has no reset; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge clock) begin
        for (int t = 0; t < NUM_TABLES; t++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (state == INIT)
                    tbl[t][init_idx][w] <= '0;
                else if (u_wr[w])
                    tbl[t][u_idx[t]][w] <= u_nxt[t][w];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_idx   <= '0;
            s1_valid <= 1'b0;
        end else if (io_s0_fire && io_s1_ready) begin
            for (int t = 0; t < NUM_TABLES; t++)
                s1_idx[t] <= io_s0_pc[INST_OFF +: IDX_W] ^ io_s0_fhist[t*IDX_W +: IDX_W];
            s1_valid <= 1'b1;
        end else if (io_s1_fire) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        logic signed [SUM_W-1:0] acc;
        logic signed [4:0]       cen;
        logic [CTR_W-1:0]        c;
        logic [SUM_W-1:0]        mag;
        logic                    sc_taken;
        for (int w = 0; w < NUM_WAYS; w++) begin
            acc = '0;
            for (int t = 0; t < NUM_TABLES; t++) begin
                c   = tbl[t][s1_idx[t]][w];
                acc = acc + $signed({{(SUM_W-CTR_W-1){c[CTR_W-1]}}, c, 1'b1});
            end
            // Centred provider confidence, 2u-7, scaled by 8.
            cen = $signed({1'b0, io_s1_tage_ctr[w*3 +: 3], 1'b0}) - 5'sd7;
            if (io_s1_tage_hit[w])
                acc = acc + $signed({{(SUM_W-8){cen[4]}}, cen, 3'b000});
            s1_sum[w]   = acc;
            mag         = acc[SUM_W-1] ? $unsigned(-acc) : $unsigned(acc);
            sc_taken    = !acc[SUM_W-1];
            s1_used[w]  = io_enable && io_s1_tage_hit[w];
            s1_over[w]  = s1_used[w] && (sc_taken != io_s1_tage_taken[w])
                          && (mag > {{(SUM_W-8){1'b0}}, thres[w]});
            s1_taken[w] = s1_over[w] ? sc_taken : io_s1_tage_taken[w];
        end
        perf_acc = {1'b0, io_perf_override};
        for (int w = 0; w < NUM_WAYS; w++)
            perf_acc = perf_acc + 17'(s1_over[w]);
        perf_nxt = perf_acc[16] ? 16'hFFFF : perf_acc[15:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_s2_valid      <= 1'b0;
            io_s2_taken      <= '0;
            io_s2_sc_used    <= '0;
            io_s2_sum        <= '0;
            io_perf_override <= '0;
        end else begin
            io_s2_valid <= io_s1_fire && s1_valid;
            if (io_s1_fire && s1_valid) begin
                io_s2_taken      <= s1_taken;
                io_s2_sc_used    <= s1_used;
                io_perf_override <= perf_nxt;
                for (int w = 0; w < NUM_WAYS; w++)
                    io_s2_sum[w*SUM_W +: SUM_W] <= s1_sum[w];
            end
        end
    end

    always_comb begin
        logic signed [SUM_W-1:0] us;
        logic [SUM_W-1:0]        umag;
        logic                    usc, ulow, act;
        logic [CTR_W-1:0]        cur;
        for (int t = 0; t < NUM_TABLES; t++)
            u_idx[t] = io_update_pc[INST_OFF +: IDX_W] ^ io_update_fhist[t*IDX_W +: IDX_W];
        for (int w = 0; w < NUM_WAYS; w++) begin
            us    = $signed(io_update_sum[w*SUM_W +: SUM_W]);
            umag  = us[SUM_W-1] ? $unsigned(-us) : $unsigned(us);
            usc   = !us[SUM_W-1];
            ulow  = umag <= {{(SUM_W-8){1'b0}}, thres[w]};
            act   = (state == READY) && io_update_valid && io_update_br_valid[w]
                    && io_update_sc_used[w];
            u_wr[w]   = act && ((usc != io_update_taken[w]) || ulow);
            tc_inc[w] = act && (usc != io_update_tage_taken[w]) && (usc != io_update_taken[w]);
            tc_dec[w] = act && (usc != io_update_tage_taken[w]) && (usc == io_update_taken[w])
                        && ulow;
            for (int t = 0; t < NUM_TABLES; t++) begin
                cur = tbl[t][u_idx[t]][w];
                if (io_update_taken[w])
                    u_nxt[t][w] = (cur == CTR_MAX) ? cur : cur + 1'b1;
                else
                    u_nxt[t][w] = (cur == CTR_MIN) ? cur : cur - 1'b1;
            end
        end
    end

    // tc saturating at +31 / -32 rolls into a threshold step and restarts from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                thres[w] <= 8'(THRES_INIT);
                tc[w]    <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (tc_inc[w]) begin
                    if (tc[w] == 6'sd30) begin
                        tc[w] <= '0;
                        if (thres[w] != 8'd255) thres[w] <= thres[w] + 8'd1;
                    end else begin
                        tc[w] <= tc[w] + 6'sd1;
                    end
                end else if (tc_dec[w]) begin
                    if (tc[w] == -6'sd31) begin
                        tc[w] <= '0;
                        if (thres[w] != 8'd4) thres[w] <= thres[w] - 8'd1;
                    end else begin
                        tc[w] <= tc[w] - 6'sd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sc_corrector_bank.sv
// Randomised bench for sc_corrector_bank against an integer-arithmetic reference model.
module tb_sc_corrector_bank;
    localparam int NT = 4, EN = 64, NW = 2, CW = 6, VA = 41, OFF = 1, IW = 6;
    localparam int SW = CW + 5 + 2;

    logic               clock = 1'b0, reset = 1'b0;
    logic               io_enable = 1'b0, io_s0_fire = 1'b0, io_s1_fire = 1'b0, io_s2_fire = 1'b0;
    logic [VA-1:0]      io_s0_pc = '0, io_update_pc = '0;
    logic [NT*IW-1:0]   io_s0_fhist = '0, io_update_fhist = '0;
    logic               io_s1_ready, io_s2_valid;
    logic [NW-1:0]      io_s1_tage_taken = '0, io_s1_tage_hit = '0;
    logic [NW*3-1:0]    io_s1_tage_ctr = '0;
    logic [NW-1:0]      io_s2_taken, io_s2_sc_used;
    logic [NW*SW-1:0]   io_s2_sum, io_update_sum = '0;
    logic               io_update_valid = 1'b0;
    logic [NW-1:0]      io_update_br_valid = '0, io_update_taken = '0;
    logic [NW-1:0]      io_update_tage_taken = '0, io_update_sc_used = '0;
    logic [15:0]        io_perf_override;

    always #5 clock = ~clock;

    sc_corrector_bank dut (
        .clock(clock), .reset(reset), .io_enable(io_enable),
        .io_s0_fire(io_s0_fire), .io_s0_pc(io_s0_pc), .io_s0_fhist(io_s0_fhist),
        .io_s1_ready(io_s1_ready), .io_s1_fire(io_s1_fire),
        .io_s1_tage_taken(io_s1_tage_taken), .io_s1_tage_hit(io_s1_tage_hit),
        .io_s1_tage_ctr(io_s1_tage_ctr), .io_s2_fire(io_s2_fire),
        .io_s2_valid(io_s2_valid), .io_s2_taken(io_s2_taken), .io_s2_sc_used(io_s2_sc_used),
        .io_s2_sum(io_s2_sum), .io_update_valid(io_update_valid), .io_update_pc(io_update_pc),
        .io_update_fhist(io_update_fhist), .io_update_br_valid(io_update_br_valid),
        .io_update_taken(io_update_taken), .io_update_tage_taken(io_update_tage_taken),
        .io_update_sc_used(io_update_sc_used), .io_update_sum(io_update_sum),
        .io_perf_override(io_perf_override)
    );

    int checks = 0, errors = 0;
    int mc [NT][EN][NW];
    int thr [NW], tc [NW];
    int perf = 0;

    longint           up_pc;
    logic [NT*IW-1:0] up_fh;
    logic [NW-1:0]    up_bv, up_tk, up_ttk, up_scu;
    int               up_sum [NW];

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int midx(input longint pc, input logic [NT*IW-1:0] fh, input int t);
        logic [IW-1:0] p, f;
        p = pc[OFF +: IW];
        f = fh[t*IW +: IW];
        return int'(p ^ f);
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int msum(input longint pc, input logic [NT*IW-1:0] fh, input int w,
                                input bit hit, input int u);
        int s = 0;
        for (int t = 0; t < NT; t++) s += 2 * mc[t][midx(pc, fh, t)][w] + 1;
        if (hit) s += (2 * u - 7) * 8;
        return s;
    endfunction

    function automatic logic [NT*IW-1:0] rand_fh();
        logic [NT*IW-1:0] f;
        for (int t = 0; t < NT; t++) f[t*IW +: IW] = IW'($urandom_range(0, 3));
        return f;
    endfunction

    task automatic drive_upd();
        io_update_valid = 1'b1;
        io_update_pc = VA'(up_pc);
        io_update_fhist = up_fh;
        io_update_br_valid = up_bv;
        io_update_taken = up_tk;
        io_update_tage_taken = up_ttk;
        io_update_sc_used = up_scu;
        for (int w = 0; w < NW; w++) io_update_sum[w*SW +: SW] = SW'(up_sum[w]);
    endtask

    task automatic model_upd();
        for (int w = 0; w < NW; w++) begin
            bit sct;
            int mag;
            if (!(up_bv[w] && up_scu[w])) continue;
            sct = up_sum[w] >= 0;
            mag = iabs(up_sum[w]);
            if (sct != up_tk[w] || mag <= thr[w])
                for (int t = 0; t < NT; t++) begin
                    int i = midx(up_pc, up_fh, t);
                    if (up_tk[w]) mc[t][i][w] = (mc[t][i][w] < 31) ? mc[t][i][w] + 1 : 31;
                    else          mc[t][i][w] = (mc[t][i][w] > -32) ? mc[t][i][w] - 1 : -32;
                end
            if (sct != up_ttk[w]) begin
                if (sct != up_tk[w]) tc[w]++;
                else if (mag <= thr[w]) tc[w]--;
                if (tc[w] == 31) begin thr[w] = (thr[w] < 255) ? thr[w] + 1 : 255; tc[w] = 0; end
                if (tc[w] == -32) begin thr[w] = (thr[w] > 4) ? thr[w] - 1 : 4; tc[w] = 0; end
            end
        end
    endtask

    task automatic set_upd(input longint pc, input logic [NW-1:0] bv, tk, ttk, scu,
                           input int s0, input int s1);
        up_pc = pc; up_fh = '0; up_bv = bv; up_tk = tk; up_ttk = ttk; up_scu = scu;
        up_sum[0] = s0; up_sum[1] = s1;
    endtask

    task automatic rand_upd();
        up_pc  = longint'($urandom_range(0, 63)) * 2 + (longint'($urandom) << 8);
        up_fh  = rand_fh();
        up_bv  = NW'($urandom);
        up_tk  = NW'($urandom);
        up_ttk = NW'($urandom);
        up_scu = NW'($urandom);
        for (int w = 0; w < NW; w++) up_sum[w] = int'($urandom_range(0, 160)) - 80;
    endtask

    task automatic upd();
        drive_upd();
        step();
        io_update_valid = 1'b0;
        model_upd();
    endtask

    task automatic pred(input longint pc, input logic [NT*IW-1:0] fh, input bit en,
                        input logic [NW-1:0] ttk, hit, input logic [NW*3-1:0] u, input bit with_upd);
        int es [NW];
        bit etk [NW], eused [NW];
        int ov = 0;
        io_s0_fire = 1'b1; io_s0_pc = VA'(pc); io_s0_fhist = fh;
        step();
        io_s0_fire = 1'b0;
        io_enable = en; io_s1_fire = 1'b1;
        io_s1_tage_taken = ttk; io_s1_tage_hit = hit; io_s1_tage_ctr = u;
        for (int w = 0; w < NW; w++) begin
            bit sct, o;
            es[w]    = msum(pc, fh, w, hit[w], int'(u[w*3 +: 3]));
            eused[w] = en && hit[w];
            sct      = es[w] >= 0;
            o        = eused[w] && (sct != ttk[w]) && (iabs(es[w]) > thr[w]);
            etk[w]   = o ? sct : ttk[w];
            ov      += int'(o);
        end
        if (with_upd) drive_upd();
        step();
        io_s1_fire = 1'b0;
        io_update_valid = 1'b0;
        if (with_upd) model_upd();
        perf = (perf + ov > 65535) ? 65535 : perf + ov;
        chk("s2_valid", io_s2_valid, 1);
        for (int w = 0; w < NW; w++) begin
            chk($sformatf("taken%0d", w), io_s2_taken[w], etk[w]);
            chk($sformatf("sc_used%0d", w), io_s2_sc_used[w], eused[w]);
            chk($sformatf("sum%0d", w), $signed(io_s2_sum[w*SW +: SW]), es[w]);
        end
        chk("perf_override", io_perf_override, perf);
        step();
        chk("s2_valid_pulse", io_s2_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw;
        for (int w = 0; w < NW; w++) begin thr[w] = 6; tc[w] = 0; end
        for (int t = 0; t < NT; t++)
            for (int e = 0; e < EN; e++)
                for (int w = 0; w < NW; w++) mc[t][e][w] = 0;

        repeat (3) step();
        chk("rst_ready", io_s1_ready, 0);
        chk("rst_s2_valid", io_s2_valid, 0);
        chk("rst_perf", io_perf_override, 0);
        chk("rst_taken", io_s2_taken, 0);
        chk("rst_sum", io_s2_sum[SW-1:0], 0);

        reset = 1'b1;
        repeat (10) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        io_s0_fire = 1'b1; io_s1_fire = 1'b1;
        n = 0; saw = 0;
        while (!io_s1_ready && n < 200) begin
            step();
            n++;
            if (io_s2_valid) saw = 1;
        end
        io_s0_fire = 1'b0; io_s1_fire = 1'b0;
        chk("init_cycles", n, EN);
        step();
        if (io_s2_valid) saw = 1;
        chk("init_no_s2", saw, 0);

        // fresh entry: sum = 4 + 8
        pred(10, '0, 1, 2'b11, 2'b11, {3'd4, 3'd4}, 0);
        // counters to +3 then TAGE disagrees with low confidence
        repeat (3) begin set_upd(20, 2'b11, 2'b11, 2'b11, 2'b11, 0, 0); upd(); end
        pred(20, '0, 1, 2'b00, 2'b11, {3'd3, 3'd3}, 0);
        pred(20, '0, 0, 2'b00, 2'b11, {3'd3, 3'd3}, 0);
        // saturation
        repeat (40) begin set_upd(30, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0); upd(); end
        pred(30, '0, 1, 2'b11, 2'b11, {3'd4, 3'd4}, 0);
        set_upd(30, 2'b01, 2'b00, 2'b01, 2'b01, 0, 0); upd();
        pred(30, '0, 1, 2'b11, 2'b11, {3'd4, 3'd4}, 0);
        // threshold raise, then decay to floor
        repeat (31) begin set_upd(40, 2'b01, 2'b00, 2'b00, 2'b01, 100, 0); upd(); end
        set_upd(50, 2'b01, 2'b01, 2'b01, 2'b01, 7, 0); upd();
        pred(50, '0, 1, 2'b11, 2'b11, {3'd4, 3'd4}, 0);
        repeat (160) begin set_upd(60, 2'b01, 2'b01, 2'b00, 2'b01, 2, 0); upd(); end
        set_upd(70, 2'b01, 2'b01, 2'b01, 2'b01, 5, 0); upd();
        pred(70, '0, 1, 2'b11, 2'b11, {3'd4, 3'd4}, 0);
        // same-cycle read/write: old value now, new value next read
        set_upd(80, 2'b11, 2'b11, 2'b11, 2'b11, 0, 0);
        pred(80, '0, 1, 2'b11, 2'b11, {3'd5, 3'd2}, 1);
        pred(80, '0, 1, 2'b11, 2'b11, {3'd5, 3'd2}, 0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rand_upd();
                upd();
            end else begin
                longint pc;
                bit wu;
                wu = $urandom_range(0, 3) == 0;
                if (wu) rand_upd();
                pc = longint'($urandom_range(0, 63)) * 2 + (longint'($urandom) << 8);
                pred(pc, rand_fh(), $urandom_range(0, 4) != 0, NW'($urandom), NW'($urandom),
                     (NW*3)'($urandom), wu);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
